// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback path.
// A writeback request is the destination register plus the value to store.
package regfile_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 2 ** AW;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

  function automatic logic [NREG-1:0] reg_onehot(input logic [AW-1:0] addr);
    reg_onehot       = '0;
    reg_onehot[addr] = 1'b1;
  endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry holding buffer for a writeback requester.
// When push and pop happen on the same edge, the slot is refilled and stays full.
module wb_slot
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t din,
  output logic    full,
  output wb_req_t dout
);

  logic    full_q;
  wb_req_t data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (push) begin
      full_q <= 1'b1;
      data_q <= din;
    end else if (pop) begin
      full_q <= 1'b0;
    end
  end

  assign full = full_q;
  assign dout = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter for the register file. Oldest held entry wins,
// so same-register writes retire in arrival order.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb0_valid,
  output logic            wb0_ready,
  input  logic [AW-1:0]   wb0_addr,
  input  logic [XLEN-1:0] wb0_data,
  input  logic            wb1_valid,
  output logic            wb1_ready,
  input  logic [AW-1:0]   wb1_addr,
  input  logic [XLEN-1:0] wb1_data,
  output logic            write_en,
  output logic [AW-1:0]   write_addr,
  output logic [XLEN-1:0] write_data,
  output logic [NREG-1:0] pending_mask
);

  logic            full0, full1;
  logic            grant0, grant1;
  logic            push0, push1;
  logic            keep0, keep1;
  logic            age_q, age_d;
  wb_req_t         din0, din1, dout0, dout1;
  logic            we_q;
  logic [AW-1:0]   waddr_q;
  logic [XLEN-1:0] wdata_q;
  logic [NREG-1:0] mask_d;

  // age_q=1 means slot 1 holds the older entry.
  assign grant0 = full0 & (~full1 | ~age_q);
  assign grant1 = full1 & (~full0 | age_q);

  assign wb0_ready = ~full0 | grant0;
  assign wb1_ready = ~full1 | grant1;

  assign push0 = wb0_valid & wb0_ready & (wb0_addr != '0);
  assign push1 = wb1_valid & wb1_ready & (wb1_addr != '0);

  assign din0 = '{addr: wb0_addr, data: wb0_data};
  assign din1 = '{addr: wb1_addr, data: wb1_data};

  assign keep0 = full0 & ~grant0;
  assign keep1 = full1 & ~grant1;

  wb_slot u_slot0 (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push0),
    .pop  (grant0),
    .din  (din0),
    .full (full0),
    .dout (dout0)
  );

  wb_slot u_slot1 (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push1),
    .pop  (grant1),
    .din  (din1),
    .full (full1),
    .dout (dout1)
  );

  // A newly filled slot is always younger than an entry that survives the edge.
  always_comb begin
    age_d = age_q;
    if (push0 && push1) begin
      age_d = 1'b0;
    end else if (push0 && keep1) begin
      age_d = 1'b1;
    end else if (push1 && keep0) begin
      age_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      age_q <= age_d;
      we_q  <= grant0 | grant1;
      if (grant0) begin
        waddr_q <= dout0.addr;
        wdata_q <= dout0.data;
      end else if (grant1) begin
        waddr_q <= dout1.addr;
        wdata_q <= dout1.data;
      end
    end
  end

  always_comb begin
    mask_d = '0;
    if (full0) mask_d = mask_d | reg_onehot(dout0.addr);
    if (full1) mask_d = mask_d | reg_onehot(dout1.addr);
    if (we_q)  mask_d = mask_d | reg_onehot(waddr_q);
  end

  assign write_en     = we_q;
  assign write_addr   = waddr_q;
  assign write_data   = wdata_q;
  assign pending_mask = mask_d;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random
// traffic, compared every cycle against an arrival-sequence reference model.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wb0Valid = 1'b0;
  logic [AW-1:0]   wb0Addr = '0;
  logic [XLEN-1:0] wb0Data = '0;
  logic            wb1Valid = 1'b0;
  logic [AW-1:0]   wb1Addr = '0;
  logic [XLEN-1:0] wb1Data = '0;
  logic            wb0Ready, wb1Ready;
  logic            writeEn;
  logic [AW-1:0]   writeAddr;
  logic [XLEN-1:0] writeData;
  logic [NREG-1:0] pendingMask;

  int errors = 0;
  int checks = 0;

  // Reference model: each slot remembers an arrival sequence number.
  bit              mFull[2];
  logic [AW-1:0]   mAddr[2];
  logic [XLEN-1:0] mData[2];
  int unsigned     mSeq[2];
  int unsigned     seqCtr = 0;
  logic            mWe = 1'b0;
  logic [AW-1:0]   mWaddr = '0;
  logic [XLEN-1:0] mWdata = '0;
  logic [XLEN-1:0] mRf[NREG];
  logic [XLEN-1:0] dutRf[NREG];

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb0_valid   (wb0Valid),
    .wb0_ready   (wb0Ready),
    .wb0_addr    (wb0Addr),
    .wb0_data    (wb0Data),
    .wb1_valid   (wb1Valid),
    .wb1_ready   (wb1Ready),
    .wb1_addr    (wb1Addr),
    .wb1_data    (wb1Data),
    .write_en    (writeEn),
    .write_addr  (writeAddr),
    .write_data  (writeData),
    .pending_mask(pendingMask)
  );

  always @(posedge clk) begin
    if (writeEn) dutRf[writeAddr] <= writeData;
  end

  function automatic int modelGrant();
    if (mFull[0] && mFull[1]) return (mSeq[0] < mSeq[1]) ? 0 : 1;
    if (mFull[0]) return 0;
    if (mFull[1]) return 1;
    return -1;
  endfunction

  task automatic modelReset();
    mFull[0] = 1'b0;
    mFull[1] = 1'b0;
    mWe      = 1'b0;
    mWaddr   = '0;
    mWdata   = '0;
  endtask

  task automatic modelEdge();
    int  g;
    bit  t0, t1;
    if (!rst_n) begin
      modelReset();
      return;
    end
    g  = modelGrant();
    t0 = wb0Valid && (!mFull[0] || g == 0);
    t1 = wb1Valid && (!mFull[1] || g == 1);
    if (mWe) mRf[mWaddr] = mWdata;
    mWe = (g >= 0);
    if (g >= 0) begin
      mWaddr   = mAddr[g];
      mWdata   = mData[g];
      mFull[g] = 1'b0;
    end
    if (t0 && wb0Addr != '0) begin
      mFull[0] = 1'b1;
      mAddr[0] = wb0Addr;
      mData[0] = wb0Data;
      mSeq[0]  = seqCtr;
      seqCtr++;
    end
    if (t1 && wb1Addr != '0) begin
      mFull[1] = 1'b1;
      mAddr[1] = wb1Addr;
      mData[1] = wb1Data;
      mSeq[1]  = seqCtr;
      seqCtr++;
    end
  endtask

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic [NREG-1:0] expMask;
    int              g;
    expMask = '0;
    for (int s = 0; s < 2; s++) if (mFull[s]) expMask[mAddr[s]] = 1'b1;
    if (mWe) expMask[mWaddr] = 1'b1;
    g = modelGrant();
    checkVal("write_en", 64'(writeEn), 64'(mWe));
    checkVal("write_addr", 64'(writeAddr), 64'(mWaddr));
    checkVal("write_data", 64'(writeData), 64'(mWdata));
    checkVal("pending_mask", 64'(pendingMask), 64'(expMask));
    checkVal("wb0_ready", 64'(wb0Ready), 64'(!mFull[0] || g == 0));
    checkVal("wb1_ready", 64'(wb1Ready), 64'(!mFull[1] || g == 1));
  endtask

  always @(posedge clk) begin
    #2;
    checkOutput();
  end

  task automatic applyStimulus(input logic v0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                               input logic v1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1);
    @(negedge clk);
    wb0Valid = v0;
    wb0Addr  = a0;
    wb0Data  = d0;
    wb1Valid = v1;
    wb1Addr  = a1;
    wb1Data  = d1;
    @(posedge clk);
    modelEdge();
    #2;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    int   writes;
    int   alts;
    logic lastBit;
    bit   first;

    for (int r = 0; r < NREG; r++) begin
      mRf[r]   = '0;
      dutRf[r] = '0;
    end
    modelReset();

    // Reset held with a request pending: nothing may transfer.
    repeat (3) applyStimulus(1'b1, 5'd9, 32'h1234, 1'b0, '0, '0);
    checkVal("reset_write_en", 64'(writeEn), 64'd0);
    checkVal("reset_mask", 64'(pendingMask), 64'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    wb0Valid = 1'b0;
    #1;
    checkVal("ready_after_reset", 64'(wb0Ready), 64'd1);

    // Single ALU write.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    checkVal("single_e_we", 64'(writeEn), 64'd0);
    checkVal("single_e_mask", 64'(pendingMask), 64'h20);
    idle();
    checkVal("single_e1_we", 64'(writeEn), 64'd1);
    checkVal("single_e1_addr", 64'(writeAddr), 64'd5);
    checkVal("single_e1_data", 64'(writeData), 64'hDEADBEEF);
    idle();
    checkVal("single_e2_mask", 64'(pendingMask), 64'd0);
    checkVal("single_rf5", 64'(dutRf[5]), 64'hDEADBEEF);

    // Simultaneous arrival to the same register.
    applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    checkVal("simul_wb1_ready", 64'(wb1Ready), 64'd0);
    checkVal("simul_wb0_ready", 64'(wb0Ready), 64'd1);
    idle();
    checkVal("simul_first_data", 64'(writeData), 64'h11);
    checkVal("simul_wb1_ready_back", 64'(wb1Ready), 64'd1);
    idle();
    checkVal("simul_second_data", 64'(writeData), 64'h22);
    idle();
    checkVal("simul_rf3", 64'(dutRf[3]), 64'h22);

    // LSU then ALU to the same register on consecutive edges.
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 32'hAA);
    applyStimulus(1'b1, 5'd7, 32'hBB, 1'b0, '0, '0);
    checkVal("order_first_data", 64'(writeData), 64'hAA);
    idle();
    checkVal("order_second_data", 64'(writeData), 64'hBB);
    idle();
    checkVal("order_rf7", 64'(dutRf[7]), 64'hBB);

    // Both ports saturated for 20 cycles.
    writes  = 0;
    alts    = 0;
    lastBit = 1'b0;
    first   = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      if (k <= 20)
        applyStimulus(1'b1, AW'(1 + (k % 15)), $urandom, 1'b1, AW'(16 + (k % 15)), $urandom);
      else
        idle();
      if (k >= 2 && k <= 21 && writeEn) begin
        writes++;
        if (!first && writeAddr[4] != lastBit) alts++;
        lastBit = writeAddr[4];
        first   = 1'b0;
      end
    end
    checkVal("throughput_writes", 64'(writes), 64'd20);
    checkVal("port_alternation", 64'(alts), 64'd19);

    // x0 write is accepted and dropped.
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0);
    checkVal("x0_mask", 64'(pendingMask), 64'd0);
    checkVal("x0_ready", 64'(wb0Ready), 64'd1);
    idle();
    checkVal("x0_we", 64'(writeEn), 64'd0);

    // Random traffic, narrow address range to provoke same-register ordering.
    repeat (400) begin
      applyStimulus(($urandom_range(0, 9) < 6), AW'($urandom_range(0, 7)), $urandom,
                    ($urandom_range(0, 9) < 6), AW'($urandom_range(0, 7)), $urandom);
    end
    repeat (3) idle();

    // Asynchronous reset while both slots and the output register are busy.
    applyStimulus(1'b1, 5'd31, 32'hA5A5_A5A5, 1'b1, 5'd31, 32'h5A5A_5A5A);
    applyStimulus(1'b1, 5'd31, 32'h1111_2222, 1'b1, 5'd31, 32'h3333_4444);
    checkVal("midflight_we_before", 64'(writeEn), 64'd1);
    #1;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkVal("midflight_we_drop", 64'(writeEn), 64'd0);
    checkVal("midflight_mask_drop", 64'(pendingMask), 64'd0);
    repeat (2) idle();
    @(negedge clk);
    rst_n = 1'b1;
    writes = 0;
    repeat (5) begin
      idle();
      if (writeEn) writes++;
    end
    checkVal("midflight_no_stale", 64'(writes), 64'd0);
    checkVal("midflight_rf31", 64'(dutRf[31]), 64'd0);

    for (int r = 0; r < NREG; r++) checkVal($sformatf("regfile_x%0d", r), 64'(dutRf[r]), 64'(mRf[r]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
